tx_serializer_10b: RTL and testbench
====================================

Name: tx_serializer_10b

Overview:
- Downstream stage of the 8b/10b data encoder. Accepts 10-bit encoded symbols through a valid/ready handshake and serializes them MSB-first (bit 9 first) onto a single-bit line.
- Tracks running disparity of the transmitted stream. When no data is available at a symbol boundary, inserts a disparity-correct K28.5 idle comma.
- Sits between the encoder's registered symbol output and the line driver / PHY.

Parameters:
- IDLE_NEG, 10'b0011111010, idle symbol sent when running disparity is negative (K28.5 RD-).
- IDLE_POS, 10'b1100000101, idle symbol sent when running disparity is positive (K28.5 RD+).
- CNT_W, 16, width of the idle insertion counter.

Ports:
- clk, input, 1, system clock; one serial bit per cycle.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, serializer enable.
- sym_in, input, 10, encoded symbol, bit 9 transmitted first.
- sym_valid, input, 1, sym_in valid.
- sym_ready, output, 1, holding register can accept sym_in this cycle.
- ser_out, output, 1, serial data bit (registered).
- sym_start, output, 1, high in the cycle ser_out carries bit 9 of a symbol.
- idle_ins, output, 1, high in the cycle ser_out carries bit 9 of an inserted idle.
- rd_out, output, 1, running disparity after the last loaded symbol (0 = RD-, 1 = RD+).
- disp_err, output, 1, one-cycle pulse: loaded data symbol had ones count not in {4,5,6}.
- idle_cnt, output, CNT_W, saturating count of idle symbols inserted.

Behaviour:
- Reset (async, rst_n=0): shift_reg=0, bit_cnt=0, active=0, hold_full=0, hold_reg=0, rd=0, sym_start=0, idle_ins=0, disp_err=0, idle_cnt=0. Outputs track: ser_out=0, rd_out=0, sym_ready=1. Reset mid-symbol abandons that symbol and discards the held symbol.
- Holding register: one entry. sym_ready = ~hold_full | load_from_hold; ready may combinationally depend on the load condition, never on sym_valid. Accept = sym_valid & sym_ready.
- Load condition: load = en & (~active | bit_cnt==9).
  - On load, shift_reg takes hold_reg if hold_full.
  - Else it takes sym_in if sym_valid (bypass, same-cycle accept and load).
  - Else it takes an idle: IDLE_NEG if rd=0, IDLE_POS if rd=1.
  - On load: bit_cnt=0, active=1, sym_start=1 next cycle; idle_ins=1 next cycle only for idle loads.
- Simultaneous load from hold and new accept: hold_reg is replaced by sym_in, hold_full stays 1.
- Accept with no load: hold_reg=sym_in, hold_full=1.
- Shifting: when active and not loading, shift_reg shifts left by one (LSB filled 0) and bit_cnt increments. ser_out = shift_reg[9]. Each symbol occupies exactly 10 consecutive cycles; symbol-to-symbol gap is zero while en=1.
- Latency: a symbol accepted while active=0 and hold empty appears at ser_out bit 9 the next cycle. Otherwise it follows the current symbol with no gap.
- Disparity, on every load, using the ones count n of the loaded symbol:
  - n>5 sets rd=1; n<5 clears rd=0; n=5 leaves rd unchanged.
  - For data loads with n<4 or n>6: disp_err pulses 1 cycle next cycle, and rd is still updated by the rule above.
  - Idle loads always flip rd.
- en deassertion: the current symbol completes all 10 bits. At bit_cnt==9 with en=0 no load occurs; active goes 0 the next cycle, ser_out=0, bit_cnt holds 0. hold_reg is retained and sym_ready follows ~hold_full.
- en assertion with active=0: load occurs in that cycle.
- idle_cnt increments on each idle load and saturates at 2^CNT_W-1; there is no wrap.
- sym_start, idle_ins and disp_err are never high when active=0.

Test Plan:
- Reset then en=1 with sym_valid=0: ser_out emits 0011111010, then 1100000101, alternating. idle_ins pulses every 10 cycles, idle_cnt=1,2,3..., rd_out toggles 1,0,1.
- en=1, present 10'b1010101010 (D21.5-like, n=5) at rd=0 with hold empty and inactive: accepted same cycle. Next 10 cycles ser_out=1,0,1,0,1,0,1,0,1,0, sym_start high in the first of them, rd_out stays 0.
- Back-to-back stream of 4 symbols held valid continuously: sym_ready low while hold is full. All 40 bits are contiguous with sym_start every 10 cycles and no idle inserted (idle_cnt unchanged).
- Load 10'b1111110000 (n=6) at rd=0: rd_out=1; next empty boundary inserts IDLE_POS. Then load 10'b1111111100 (n=8): disp_err pulses once and rd_out=1.
- Drop en at bit_cnt=3 with one symbol held: current symbol finishes (7 more bits) then ser_out=0, active=0, sym_ready=0. Re-assert en: the held symbol is sent first with no idle.
- Assert rst_n=0 mid-symbol with hold full: all outputs go to reset values immediately. After release with en=1 and no data, the first symbol is IDLE_NEG.

Source files
------------

// File: rtl/tx_serializer_10b_if.sv
// tx_serializer_10b_if: symbol handshake between the 8b/10b encoder and the serializer.
//   sym_in    : 10-bit encoded symbol, bit 9 goes on the line first
//   sym_valid : sym_in is valid
//   sym_ready : serializer can take sym_in this cycle
interface tx_serializer_10b_if;
  logic [9:0] sym_in;
  logic sym_valid;
  logic sym_ready;
  modport master (output sym_in, sym_valid, input sym_ready);
  modport slave (input sym_in, sym_valid, output sym_ready);
endinterface

// File: rtl/tx_serializer_10b.sv
// tx_serializer_10b: serializes 10-bit symbols MSB-first, inserts K28.5 idles and tracks running disparity.
//   clk, rst_n : clock (one serial bit per cycle), async active-low reset
//   en         : serializer enable
//   s          : symbol handshake (sym_in / sym_valid / sym_ready)
//   ser_out    : serial bit
//   sym_start  : ser_out carries bit 9 of a symbol
//   idle_ins   : ser_out carries bit 9 of an inserted idle
//   rd_out     : running disparity after the last loaded symbol (1 = RD+)
//   disp_err   : loaded data symbol had an unbalanced ones count
//   idle_cnt   : saturating count of inserted idles
module tx_serializer_10b #(
  parameter logic [9:0] IDLE_NEG = 10'b0011111010,
  parameter logic [9:0] IDLE_POS = 10'b1100000101,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  tx_serializer_10b_if.slave s,
  output logic ser_out,
  output logic sym_start,
  output logic idle_ins,
  output logic rd_out,
  output logic disp_err,
  output logic [CNT_W-1:0] idle_cnt
);
  logic [9:0] shift_reg, hold_reg, ld_sym;
  logic [3:0] bit_cnt, ones;
  logic active, hold_full, rd, load, from_hold, accept, bypass, idle_ld;
  assign load = en & (~active | bit_cnt == 4'd9);
  assign from_hold = load & hold_full;
  assign s.sym_ready = ~hold_full | from_hold;
  assign accept = s.sym_valid & s.sym_ready;
  // an empty holding register lets sym_in go straight into the shifter
  assign bypass = load & ~hold_full & s.sym_valid;
  assign idle_ld = load & ~hold_full & ~s.sym_valid;
  assign ld_sym = hold_full ? hold_reg : s.sym_valid ? s.sym_in : rd ? IDLE_POS : IDLE_NEG;
  assign ones = 4'($countones(ld_sym));
  assign ser_out = shift_reg[9];
  assign rd_out = rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt <= '0;
      active <= 1'b0;
      hold_full <= 1'b0;
      hold_reg <= '0;
      rd <= 1'b0;
      sym_start <= 1'b0;
      idle_ins <= 1'b0;
      disp_err <= 1'b0;
      idle_cnt <= '0;
    end else begin
      sym_start <= load;
      idle_ins <= idle_ld;
      disp_err <= load & ~idle_ld & (ones < 4'd4 | ones > 4'd6);
      if (load) begin
        shift_reg <= ld_sym;
        bit_cnt <= 4'd0;
        active <= 1'b1;
        rd <= idle_ld ? ~rd : ones > 4'd5 ? 1'b1 : ones < 4'd5 ? 1'b0 : rd;
      end else if (active) begin
        // last bit shifted out without a reload leaves the line at 0
        shift_reg <= {shift_reg[8:0], 1'b0};
        bit_cnt <= bit_cnt == 4'd9 ? 4'd0 : bit_cnt + 4'd1;
        active <= bit_cnt != 4'd9;
      end
      if (accept & ~bypass) begin
        hold_reg <= s.sym_in;
        hold_full <= 1'b1;
      end else if (from_hold) begin
        hold_full <= 1'b0;
      end
      if (idle_ld & ~&idle_cnt) idle_cnt <= idle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_tx_serializer_10b.sv
// tb_tx_serializer_10b: directed bench for tx_serializer_10b.
module tb_tx_serializer_10b;
  localparam logic [9:0] IN = 10'b0011111010;
  localparam logic [9:0] IP = 10'b1100000101;
  localparam logic [9:0] SA = 10'b1110001010;
  localparam logic [9:0] SB = 10'b0101100110;
  localparam logic [9:0] SC = 10'b1001110001;
  localparam logic [9:0] SD = 10'b0110010011;
  localparam logic [9:0] SE = 10'b1011001001;
  localparam logic [9:0] SF = 10'b0100110110;
  logic clk = 1'b0;
  logic rst_n, en;
  logic ser_out, sym_start, idle_ins, rd_out, disp_err;
  logic [15:0] idle_cnt;
  int pass = 0, total = 0;
  logic [9:0] q[$];
  tx_serializer_10b_if s();
  tx_serializer_10b dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s.slave),
    .ser_out(ser_out), .sym_start(sym_start), .idle_ins(idle_ins),
    .rd_out(rd_out), .disp_err(disp_err), .idle_cnt(idle_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // valid/ready source: handshake sampled at negedge, queue advanced after the edge
  initial begin
    logic acc;
    s.sym_valid = 1'b0;
    s.sym_in = '0;
    forever begin
      @(negedge clk);
      acc = s.sym_valid & s.sym_ready;
      @(posedge clk);
      #2;
      if (acc && q.size() > 0) void'(q.pop_front());
      s.sym_valid = q.size() > 0;
      if (q.size() > 0) s.sym_in = q[0];
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    q.delete();
    s.sym_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask
  // captures one 10-bit symbol starting at the next edge (the load edge)
  task automatic cap(input string tag, input logic [9:0] exp, input logic exp_idle,
                     input logic exp_err, input int rdy_mid, input int drop_at);
    logic [9:0] b = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      b = {b[8:0], ser_out};
      if (i == 0) begin
        chk({tag, "_start"}, sym_start, 1'b1);
        chk({tag, "_idle"}, idle_ins, exp_idle);
        chk({tag, "_err"}, disp_err, exp_err);
      end
      if (i == 1) begin
        chk({tag, "_start_pulse"}, sym_start, 1'b0);
        chk({tag, "_err_pulse"}, disp_err, 1'b0);
      end
      if (i == 4 && rdy_mid >= 0) chk({tag, "_ready"}, s.sym_ready, rdy_mid[0]);
      if (i == drop_at) en = 1'b0;
    end
    chk({tag, "_bits"}, b, exp);
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    step();
    chk("rst_ser", ser_out, 1'b0);
    chk("rst_rd", rd_out, 1'b0);
    chk("rst_ready", s.sym_ready, 1'b1);
    chk("rst_cnt", idle_cnt, 16'd0);
    chk("rst_start", sym_start, 1'b0);
    chk("rst_idle", idle_ins, 1'b0);
    chk("rst_err", disp_err, 1'b0);
    do_reset();
    en = 1'b1;
    cap("idle1", IN, 1'b1, 1'b0, -1, -1);
    chk("idle1_cnt", idle_cnt, 16'd1);
    chk("idle1_rd", rd_out, 1'b1);
    cap("idle2", IP, 1'b1, 1'b0, -1, -1);
    chk("idle2_cnt", idle_cnt, 16'd2);
    chk("idle2_rd", rd_out, 1'b0);
    cap("idle3", IN, 1'b1, 1'b0, -1, -1);
    chk("idle3_cnt", idle_cnt, 16'd3);
    chk("idle3_rd", rd_out, 1'b1);
    do_reset();
    en = 1'b1;
    q.push_back(10'b1010101010);
    cap("d21", 10'b1010101010, 1'b0, 1'b0, 1, -1);
    chk("d21_rd", rd_out, 1'b0);
    q.push_back(SA);
    q.push_back(SB);
    q.push_back(SC);
    q.push_back(SD);
    cap("bb_a", SA, 1'b0, 1'b0, 0, -1);
    cap("bb_b", SB, 1'b0, 1'b0, 0, -1);
    cap("bb_c", SC, 1'b0, 1'b0, 0, -1);
    cap("bb_d", SD, 1'b0, 1'b0, 1, -1);
    chk("bb_cnt", idle_cnt, 16'd0);
    chk("bb_rd", rd_out, 1'b0);
    q.push_back(10'b1111110000);
    cap("n6", 10'b1111110000, 1'b0, 1'b0, -1, -1);
    chk("n6_rd", rd_out, 1'b1);
    cap("idle_pos", IP, 1'b1, 1'b0, -1, -1);
    chk("idle_pos_cnt", idle_cnt, 16'd1);
    chk("idle_pos_rd", rd_out, 1'b0);
    q.push_back(10'b1111111100);
    cap("n8", 10'b1111111100, 1'b0, 1'b1, -1, -1);
    chk("n8_rd", rd_out, 1'b1);
    q.push_back(SE);
    q.push_back(SF);
    cap("pause_e", SE, 1'b0, 1'b0, 0, 3);
    step();
    chk("pause_ser", ser_out, 1'b0);
    chk("pause_ready", s.sym_ready, 1'b0);
    chk("pause_start", sym_start, 1'b0);
    repeat (3) step();
    chk("pause_ser_hold", ser_out, 1'b0);
    chk("pause_cnt", idle_cnt, 16'd1);
    en = 1'b1;
    cap("resume_f", SF, 1'b0, 1'b0, 1, -1);
    chk("resume_cnt", idle_cnt, 16'd1);
    chk("resume_rd", rd_out, 1'b1);
    q.push_back(SA);
    q.push_back(SB);
    repeat (3) step();
    chk("pre_rst_ready", s.sym_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ser", ser_out, 1'b0);
    chk("arst_ready", s.sym_ready, 1'b1);
    chk("arst_rd", rd_out, 1'b0);
    chk("arst_cnt", idle_cnt, 16'd0);
    chk("arst_start", sym_start, 1'b0);
    do_reset();
    en = 1'b1;
    cap("post_rst", IN, 1'b1, 1'b0, -1, -1);
    chk("post_rst_cnt", idle_cnt, 16'd1);
    chk("post_rst_rd", rd_out, 1'b1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
